// File: rtl/axis_pgroup_packer_if.sv
// axis_pgroup_packer_if: pixel-word input and AXI-Stream pixel-group output bundle.
interface axis_pgroup_packer_if #(
    parameter int IN_DATA_W    = 64,
    parameter int IP_DATA_W    = 256,
    parameter int AXIS_TID_W   = 2,
    parameter int AXIS_TDEST_W = 1
);
    logic [IN_DATA_W-1:0]    s_data_i;
    logic                    s_valid_i;
    logic                    s_ready_o;
    logic [AXIS_TID_W-1:0]   m_tid_o;
    logic [AXIS_TDEST_W-1:0] m_tdest_o;
    logic [IP_DATA_W-1:0]    m_tdata_o;
    logic [IP_DATA_W/8-1:0]  m_tkeep_o;
    logic [IP_DATA_W/8-1:0]  m_tstrb_o;
    logic                    m_tlast_o;
    logic                    m_tvalid_o;
    logic                    m_tready_i;
    logic                    frame_done_o;

    modport master (
        input  s_data_i, s_valid_i, m_tready_i,
        output s_ready_o, m_tid_o, m_tdest_o, m_tdata_o, m_tkeep_o, m_tstrb_o,
               m_tlast_o, m_tvalid_o, frame_done_o
    );

    modport slave (
        output s_data_i, s_valid_i, m_tready_i,
        input  s_ready_o, m_tid_o, m_tdest_o, m_tdata_o, m_tkeep_o, m_tstrb_o,
               m_tlast_o, m_tvalid_o, frame_done_o
    );
endinterface

// File: rtl/axis_pgroup_packer.sv
// axis_pgroup_packer: packs narrow pixel words into wide groups with per-frame TDEST rotation.
module axis_pgroup_packer #(
    parameter int IN_DATA_W    = 64,
    parameter int IP_AMT       = 1,
    parameter int IP_DATA_W    = 256,
    parameter int PG_PER_FRAME = 1200,
    parameter int AXIS_TID_W   = 2,
    parameter int AXIS_TID_VAL = 0,
    parameter int AXIS_TDEST_W = (IP_AMT > 1) ? $clog2(IP_AMT) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear_i,
    axis_pgroup_packer_if.master bus
);
    localparam int RATIO = IP_DATA_W / IN_DATA_W;
    localparam int WC_W  = $clog2(RATIO);
    localparam int PG_W  = (PG_PER_FRAME > 1) ? $clog2(PG_PER_FRAME) : 1;
    localparam int ASM_W = IP_DATA_W - IN_DATA_W;

    logic [WC_W-1:0]         word_cnt_q, word_cnt_d;
    logic [PG_W-1:0]         pg_cnt_q, pg_cnt_d;
    logic [AXIS_TDEST_W-1:0] dest_cnt_q, dest_cnt_d;
    logic [ASM_W-1:0]        asm_q, asm_d;
    logic [IP_DATA_W-1:0]    tdata_q, tdata_d;
    logic [AXIS_TDEST_W-1:0] tdest_q, tdest_d;
    logic                    tlast_q, tlast_d;
    logic                    tvalid_q, tvalid_d;
    logic                    done_q, done_d;
    logic                    s_ready, accept, last_word, complete, pg_last, dest_last;

    always_comb begin
        last_word  = word_cnt_q == WC_W'(RATIO - 1);
        pg_last    = pg_cnt_q == PG_W'(PG_PER_FRAME - 1);
        dest_last  = dest_cnt_q == AXIS_TDEST_W'(IP_AMT - 1);
        // a completing word may enter while the old group drains this cycle
        s_ready    = ~rst & ~clear_i & ~(last_word & tvalid_q & ~bus.m_tready_i);
        accept     = bus.s_valid_i & s_ready;
        complete   = accept & last_word;
        word_cnt_d = clear_i ? '0 : !accept ? word_cnt_q : last_word ? '0 : word_cnt_q + 1'b1;
        pg_cnt_d   = clear_i ? '0 : !complete ? pg_cnt_q : pg_last ? '0 : pg_cnt_q + 1'b1;
        dest_cnt_d = !(complete & pg_last) ? dest_cnt_q : dest_last ? '0 : dest_cnt_q + 1'b1;
        asm_d      = asm_q;
        for (int i = 0; i < RATIO - 1; i++)
            if (accept && word_cnt_q == WC_W'(i)) asm_d[i*IN_DATA_W +: IN_DATA_W] = bus.s_data_i;
        tvalid_d   = complete | (tvalid_q & ~bus.m_tready_i);
        tdata_d    = complete ? {bus.s_data_i, asm_q} : tdata_q;
        tdest_d    = complete ? dest_cnt_q : tdest_q;
        tlast_d    = complete ? pg_last : tlast_q;
        done_d     = tvalid_q & bus.m_tready_i & tlast_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_q <= '0;
            pg_cnt_q   <= '0;
            dest_cnt_q <= '0;
            asm_q      <= '0;
            tdata_q    <= '0;
            tdest_q    <= '0;
            tlast_q    <= 1'b0;
            tvalid_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            word_cnt_q <= word_cnt_d;
            pg_cnt_q   <= pg_cnt_d;
            dest_cnt_q <= dest_cnt_d;
            asm_q      <= asm_d;
            tdata_q    <= tdata_d;
            tdest_q    <= tdest_d;
            tlast_q    <= tlast_d;
            tvalid_q   <= tvalid_d;
            done_q     <= done_d;
        end
    end

    assign bus.s_ready_o    = s_ready;
    assign bus.m_tid_o      = AXIS_TID_W'(AXIS_TID_VAL);
    assign bus.m_tdest_o    = tdest_q;
    assign bus.m_tdata_o    = tdata_q;
    assign bus.m_tkeep_o    = '1;
    assign bus.m_tstrb_o    = '1;
    assign bus.m_tlast_o    = tlast_q;
    assign bus.m_tvalid_o   = tvalid_q;
    assign bus.frame_done_o = done_q;
endmodule

// File: tb/tb_axis_pgroup_packer.sv
// tb_axis_pgroup_packer: directed and random stimulus against a group-level scoreboard model.
module tb_axis_pgroup_packer;
    localparam int PGF = 3;
    localparam int NIP = 2;

    typedef struct {
        logic [255:0] d;
        logic         dest;
        logic         last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;

    axis_pgroup_packer_if #(.IN_DATA_W(64), .IP_DATA_W(256), .AXIS_TID_W(2), .AXIS_TDEST_W(1)) bus ();

    axis_pgroup_packer #(
        .IN_DATA_W(64), .IP_AMT(NIP), .IP_DATA_W(256), .PG_PER_FRAME(PGF),
        .AXIS_TID_W(2), .AXIS_TID_VAL(0), .AXIS_TDEST_W(1)
    ) dut (
        .clk(clk), .rst(rst), .clear_i(clear), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    int n_beats = 0, n_last = 0, n_acc = 0;
    logic [63:0] part[$];
    beat_t exp_q[$];
    int m_pg = 0, m_dest = 0;
    logic done_exp = 1'b0, stall = 1'b0, held_last = 1'b0, held_dest = 1'b0;
    logic [255:0] held_d = '0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // a group is four accepted words, first word in the LSBs; frames of PGF groups rotate dest
    task automatic model_push(input logic [63:0] w);
        beat_t b;
        part.push_back(w);
        if (part.size() == 4) begin
            b.d = {part[3], part[2], part[1], part[0]};
            b.dest = m_dest[0];
            b.last = (m_pg == PGF - 1);
            exp_q.push_back(b);
            part.delete();
            m_pg = (m_pg + 1) % PGF;
            if (b.last) m_dest = (m_dest + 1) % NIP;
        end
    endtask

    task automatic cyc();
        beat_t b;
        @(negedge clk);
        if (stall) begin
            chk("hold_data", bus.m_tdata_o, held_d);
            chk("hold_last", bus.m_tlast_o, held_last);
            chk("hold_dest", bus.m_tdest_o, held_dest);
            chk("hold_valid", bus.m_tvalid_o, 1'b1);
        end
        chk("frame_done", bus.frame_done_o, done_exp);
        done_exp = 1'b0;
        if (!rst && bus.m_tvalid_o && bus.m_tready_i) begin
            n_beats++;
            chk("beat_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                b = exp_q.pop_front();
                chk("tdata", bus.m_tdata_o, b.d);
                chk("tdest", bus.m_tdest_o, b.dest);
                chk("tlast", bus.m_tlast_o, b.last);
            end
            done_exp = bus.m_tlast_o;
            if (bus.m_tlast_o) n_last++;
        end
        stall = !rst && bus.m_tvalid_o && !bus.m_tready_i;
        held_d = bus.m_tdata_o;
        held_last = bus.m_tlast_o;
        held_dest = bus.m_tdest_o[0];
        if (bus.s_valid_i && bus.s_ready_o) begin
            n_acc++;
            model_push(bus.s_data_i);
        end
        if (clear) begin
            part.delete();
            m_pg = 0;
        end
        if (rst) begin
            part.delete();
            exp_q.delete();
            m_pg = 0;
            m_dest = 0;
            done_exp = 1'b0;
            stall = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] w);
        bus.s_valid_i = 1'b1;
        bus.s_data_i = w;
        cyc();
        bus.s_valid_i = 1'b0;
    endtask

    initial begin
        int b0, l0, a0, budget;
        bus.s_valid_i = 1'b0;
        bus.s_data_i = '0;
        bus.m_tready_i = 1'b1;
        cyc();
        cyc();
        chk("rst_s_ready", bus.s_ready_o, 1'b0);
        chk("rst_tvalid", bus.m_tvalid_o, 1'b0);
        chk("rst_tdata", bus.m_tdata_o, 256'h0);
        chk("rst_tlast", bus.m_tlast_o, 1'b0);
        chk("rst_tdest", bus.m_tdest_o, 1'b0);
        chk("rst_done", bus.frame_done_o, 1'b0);
        chk("tkeep", bus.m_tkeep_o, {32{1'b1}});
        chk("tstrb", bus.m_tstrb_o, {32{1'b1}});
        chk("tid", bus.m_tid_o, 2'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_s_ready", bus.s_ready_o, 1'b1);

        for (int i = 0; i < 4; i++) send(64'(i) * 64'h1111_1111_1111_1111);
        chk("basic_tvalid", bus.m_tvalid_o, 1'b1);
        chk("basic_tdata", bus.m_tdata_o,
            256'h3333333333333333_2222222222222222_1111111111111111_0000000000000000);
        chk("basic_tdest", bus.m_tdest_o, 1'b0);
        chk("basic_tlast", bus.m_tlast_o, 1'b0);
        cyc();
        chk("basic_drained", bus.m_tvalid_o, 1'b0);

        clear = 1'b1;
        cyc();
        clear = 1'b0;
        b0 = n_beats;
        l0 = n_last;
        for (int i = 0; i < 24; i++) send({$urandom, $urandom});
        cyc();
        cyc();
        chk("rot_beats", n_beats - b0, 6);
        chk("rot_lasts", n_last - l0, 2);

        bus.m_tready_i = 1'b0;
        b0 = n_beats;
        for (int i = 0; i < 8; i++) begin
            bus.s_valid_i = 1'b1;
            bus.s_data_i = {$urandom, $urandom};
            #1;
            chk("bp_s_ready", bus.s_ready_o, i != 7);
            if (i != 7) cyc();
        end
        cyc();
        chk("bp_held_valid", bus.m_tvalid_o, 1'b1);
        bus.m_tready_i = 1'b1;
        #1;
        chk("bp_release_ready", bus.s_ready_o, 1'b1);
        cyc();
        bus.s_valid_i = 1'b0;
        chk("bp_beat2_valid", bus.m_tvalid_o, 1'b1);
        cyc();
        chk("bp_beats", n_beats - b0, 2);
        chk("bp_pending", exp_q.size(), 0);

        send({$urandom, $urandom});
        send({$urandom, $urandom});
        clear = 1'b1;
        bus.s_valid_i = 1'b1;
        #1;
        chk("clear_s_ready", bus.s_ready_o, 1'b0);
        cyc();
        clear = 1'b0;
        bus.s_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) send({$urandom, $urandom});
        chk("flush_tvalid", bus.m_tvalid_o, 1'b1);
        chk("flush_tlast", bus.m_tlast_o, 1'b0);
        chk("flush_tdest", bus.m_tdest_o, 1'(m_dest));
        cyc();

        for (int i = 0; i < 16; i++) send({$urandom, $urandom});
        cyc();
        bus.m_tready_i = 1'b0;
        for (int i = 0; i < 4; i++) send({$urandom, $urandom});
        chk("pre_rst_tvalid", bus.m_tvalid_o, 1'b1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("midrst_tvalid", bus.m_tvalid_o, 1'b0);
        chk("midrst_s_ready", bus.s_ready_o, 1'b1);
        bus.m_tready_i = 1'b1;
        b0 = n_beats;
        l0 = n_last;
        for (int i = 0; i < 12; i++) send({$urandom, $urandom});
        cyc();
        cyc();
        chk("midrst_beats", n_beats - b0, 3);
        chk("midrst_lasts", n_last - l0, 1);

        a0 = n_acc;
        l0 = n_last;
        budget = 4000;
        while (n_acc - a0 < 120 && budget > 0) begin
            bus.s_valid_i = 1'($urandom_range(0, 1));
            bus.s_data_i = {$urandom, $urandom};
            bus.m_tready_i = 1'($urandom_range(0, 1));
            cyc();
            budget--;
        end
        bus.s_valid_i = 1'b0;
        bus.m_tready_i = 1'b1;
        chk("rand_accepted", n_acc - a0, 120);
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            cyc();
            budget--;
        end
        cyc();
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_partial", part.size(), 0);
        chk("rand_lasts", n_last - l0, 10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
